// File: rtl/seq_run_ctrl_pkg.sv
// Shared types and widths for the run-length detector: state encoding,
// threshold/counter widths and saturation limits.
package seq_run_ctrl_pkg;

  localparam int THR_W = 4;  // threshold holds 1..8
  localparam int RUN_W = 4;  // run length saturates at the threshold
  localparam int HIT_W = 8;  // hit counter saturates at 255

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN0 = 2'd1;
  localparam logic [1:0] STATE_RUN1 = 2'd2;

  localparam logic [HIT_W-1:0] HIT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_RUN0 = STATE_RUN0,
    ST_RUN1 = STATE_RUN1
  } run_state_e;

  // Threshold N encoded from the 3-bit configuration code (N = code + 1).
  function automatic logic [THR_W-1:0] len_from_code(input logic [2:0] code);
    return {1'b0, code} + THR_W'(1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear, restart-to-one and increment controls.
// Priority: reset > clear > restart > increment; holds once it reaches limit.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             restart,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clr) begin
      count_next = '0;
    end else if (restart) begin
      count_next = WIDTH'(1);
    end else if (inc && (count_reg < limit)) begin
      count_next = count_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/seq_run_ctrl.sv
// Serial run-length detector: tracks the current run of equal bits on w,
// flags runs reaching a programmable length N and counts how many did.
module seq_run_ctrl
  import seq_run_ctrl_pkg::*;
#(
  parameter int DEFAULT_LEN = 4
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             w,
  input  logic             en,
  input  logic             cfg_load,
  input  logic [2:0]       cfg_len,
  input  logic             clr_hits,
  output logic             z,
  output logic             zval,
  output logic [RUN_W-1:0] run_cnt,
  output logic [HIT_W-1:0] hit_cnt,
  output logic [1:0]       state
);

  run_state_e       state_reg;
  run_state_e       state_next;
  logic [THR_W-1:0] threshold_reg;
  logic [RUN_W-1:0] run_cnt_q;
  logic             run_clr;
  logic             run_restart;
  logic             run_inc;
  logic             hit;

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_reg     <= ST_IDLE;
      threshold_reg <= THR_W'(DEFAULT_LEN);
    end else begin
      state_reg <= state_next;
      if (cfg_load) begin
        threshold_reg <= len_from_code(cfg_len);
      end
    end
  end

  // A run reaches N either by growing into it (run_cnt+1 == N) or, for N=1,
  // on the very first sample of a new run; saturated runs never re-count.
  always_comb begin
    state_next  = state_reg;
    run_clr     = 1'b0;
    run_restart = 1'b0;
    run_inc     = 1'b0;
    hit         = 1'b0;
    if (cfg_load) begin
      state_next = ST_IDLE;
      run_clr    = 1'b1;
    end else if (en) begin
      case (state_reg)
        ST_IDLE: begin
          state_next  = w ? ST_RUN1 : ST_RUN0;
          run_restart = 1'b1;
          hit         = (threshold_reg == THR_W'(1));
        end
        ST_RUN0: begin
          if (!w) begin
            run_inc = 1'b1;
            hit     = ((run_cnt_q + RUN_W'(1)) == threshold_reg);
          end else begin
            state_next  = ST_RUN1;
            run_restart = 1'b1;
            hit         = (threshold_reg == THR_W'(1));
          end
        end
        ST_RUN1: begin
          if (w) begin
            run_inc = 1'b1;
            hit     = ((run_cnt_q + RUN_W'(1)) == threshold_reg);
          end else begin
            state_next  = ST_RUN0;
            run_restart = 1'b1;
            hit         = (threshold_reg == THR_W'(1));
          end
        end
        default: begin
          state_next = ST_IDLE;
          run_clr    = 1'b1;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (RUN_W)
  ) u_run_cnt (
    .clk     (Clk),
    .resetn  (Resetn),
    .clr     (run_clr),
    .restart (run_restart),
    .inc     (run_inc),
    .limit   (threshold_reg),
    .count   (run_cnt_q)
  );

  sat_counter #(
    .WIDTH (HIT_W)
  ) u_hit_cnt (
    .clk     (Clk),
    .resetn  (Resetn),
    .clr     (clr_hits),
    .restart (1'b0),
    .inc     (hit),
    .limit   (HIT_MAX),
    .count   (hit_cnt)
  );

  assign run_cnt = run_cnt_q;
  assign state   = state_reg;
  assign zval    = (state_reg == ST_RUN1);
  assign z       = (state_reg != ST_IDLE) && (run_cnt_q == threshold_reg);

endmodule

// File: doc/seq_run_ctrl.md
SEQ_RUN_CTRL -- requirements
Module: seq_run_ctrl

Interface
REQ-001 Parameter DEFAULT_LEN, default 4, run-length threshold N loaded at reset (legal 1..8).
REQ-002 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Resetn  input  1  reset, synchronous, active-low.
REQ-004 w  input  1  serial data bit sampled for runs.
REQ-005 en  input  1  sample enable; when low, all state holds.
REQ-006 cfg_load  input  1  load new threshold from cfg_len.
REQ-007 cfg_len  input  3  threshold code; N = cfg_len + 1 (1..8).
REQ-008 clr_hits  input  1  clears hit counter.
REQ-009 z  output  1  high while the current run length equals N.
REQ-010 zval  output  1  polarity of the current run (1 = ones, 0 = zeros).
REQ-011 run_cnt  output  4  current run length, saturating at N.
REQ-012 hit_cnt  output  8  number of runs that reached N, saturating at 255.
REQ-013 state  output  2  FSM state code: IDLE=0, RUN0=1, RUN1=2.

Function
REQ-014 FSM SHALL have three states: IDLE (no valid sample), RUN0 (run of zeros), RUN1 (run of ones).
REQ-015 Edge with en=1 in IDLE: go to RUN1 if w=1, else RUN0; run_cnt <= 1.
REQ-016 Edge with en=1 in RUNx and w=x: run_cnt <= min(run_cnt+1, N); state unchanged.
REQ-017 Edge with en=1 in RUNx and w!=x: switch to the other RUN state; run_cnt <= 1.
REQ-018 z SHALL be a Moore output of registers: z = (state!=IDLE) and (run_cnt==N); no combinational path from w.
REQ-019 Latency: z rises immediately after the edge that samples the Nth consecutive equal bit.
REQ-020 zval SHALL equal 1 in RUN1, 0 in RUN0 and IDLE.
REQ-021 hit_cnt SHALL increment on an edge where the next run_cnt equals N and either the current run_cnt < N or the state changes polarity; each run counts once.
REQ-022 N=1: every sample is a hit on a polarity change; z stays high from the first sample onward.
REQ-023 hit_cnt SHALL saturate at 255 and not wrap.
REQ-024 Edge with cfg_load=1: threshold <= cfg_len+1, state <= IDLE, run_cnt <= 0, regardless of en; hit_cnt unaffected.
REQ-025 Edge with clr_hits=1: hit_cnt <= 0; clear wins over a simultaneous increment.
REQ-026 Priority per edge: Resetn low > cfg_load > en-driven update; clr_hits is independent of cfg_load and en.
REQ-027 en=0 SHALL freeze state, run_cnt and threshold; cfg_load and clr_hits still act.

Reset
REQ-028 Edge with Resetn=0: state=IDLE, run_cnt=0, hit_cnt=0, threshold=DEFAULT_LEN, hence z=0, zval=0.
REQ-029 Reset mid-run SHALL discard the run; the first sample after release starts a new run of length 1.

Structure
REQ-030 Shared package holds the state enum (IDLE/RUN0/RUN1), the state-code constants and the threshold/counter widths.
REQ-031 One sub-module, sat_counter (parameterised width, increment, clear, saturation limit), SHALL implement run_cnt and hit_cnt.

Verification
REQ-032 Reset, N=4, w=1 for 4 enabled edges -> z=1 after the 4th edge, run_cnt=4, hit_cnt=1, zval=1.
REQ-033 N=4, w = 1,1,1,1,1,1,0 -> run_cnt holds at 4 and z stays high through the 6th edge; after the 0, run_cnt=1, z=0, hit_cnt=1.
REQ-034 cfg_len=0 (N=1), w = 0,1,0 -> z=1 after every edge, hit_cnt=3, zval toggles 0,1,0.
REQ-035 N=4, 3 ones, then en=0 for 5 edges with w=1, then one enabled 1 -> z rises only after the enabled edge, hit_cnt=1.
REQ-036 Mid-run (run_cnt=3), cfg_load with cfg_len=1 -> state=IDLE, run_cnt=0; next two equal bits give z=1.
REQ-037 Force 256 hits with N=1 -> hit_cnt saturates at 255; clr_hits on a hit edge -> hit_cnt=0.
